fxp_div_q16: RTL and testbench

FXP_DIV_Q16 -- requirements
Module: fxp_div_q16

---
 rtl/fxp_div_q16.sv | 163 ++++++++++++++++
 tb/tb_fxp_div_q16.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fxp_div_q16.sv
// Signed Q(32-FRAC).FRAC divider: restoring shift-subtract, one quotient bit per cycle, truncating and saturating.
// Result is held in DONE until out_ready; new operands are taken only in IDLE.
module fxp_div_q16 #(
  parameter int FRAC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] q,
  output logic               ovf,
  output logic               div_zero
);

  localparam int W  = 32 + FRAC;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [31:0]     dvs_q, dvs_d;
  logic            neg_q, neg_d;
  logic [31:0]     q_q, q_d;
  logic            ovf_q, ovf_d;
  logic            dz_q, dz_d;

  logic [31:0]     a_u, b_u;
  logic [31:0]     mag_a, mag_b;
  logic [31:0]     rem_shift;
  logic            fits;
  logic [W-1:0]    quo_nxt;

  assign a_u = a;
  assign b_u = b;

  assign mag_a = a_u[31] ? (~a_u + 32'd1) : a_u;
  assign mag_b = b_u[31] ? (~b_u + 32'd1) : b_u;

  // The shifted remainder is 33 bits wide; its top bit is rem_q[31], which
  // forces a subtract, and the low 32 bits of the difference are then exact.
  assign rem_shift = {rem_q[30:0], quo_q[W-1]};
  assign fits      = rem_q[31] | (rem_shift >= dvs_q);
  assign quo_nxt   = {quo_q[W-2:0], fits};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    q_d     = q_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (b_u == 32'd0) begin
            state_d = DONE;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            if (a_u == 32'd0) begin
              q_d = 32'd0;
            end else if (a_u[31]) begin
              q_d = 32'h8000_0000;
            end else begin
              q_d = 32'h7FFF_FFFF;
            end
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = 32'd0;
            quo_d   = W'(mag_a) << FRAC;
            dvs_d   = mag_b;
            neg_d   = a_u[31] ^ b_u[31];
          end
        end
      end

      CALC: begin
        rem_d = fits ? (rem_shift - dvs_q) : rem_shift;
        quo_d = quo_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          dz_d    = 1'b0;
          // Negative results may reach 2^31 in magnitude; positive ones stop at 2^31-1.
          if (neg_q) begin
            if (quo_nxt > W'(32'h8000_0000)) begin
              q_d   = 32'h8000_0000;
              ovf_d = 1'b1;
            end else begin
              q_d   = ~quo_nxt[31:0] + 32'd1;
              ovf_d = 1'b0;
            end
          end else begin
            if (quo_nxt > W'(32'h7FFF_FFFF)) begin
              q_d   = 32'h7FFF_FFFF;
              ovf_d = 1'b1;
            end else begin
              q_d   = quo_nxt[31:0];
              ovf_d = 1'b0;
            end
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= 32'd0;
      quo_q   <= '0;
      dvs_q   <= 32'd0;
      neg_q   <= 1'b0;
      q_q     <= 32'd0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign ovf       = ovf_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_fxp_div_q16.sv
// Directed table of Q16.16 divisions with hand-computed results, plus hold, reset-abort and reset-priority sequences.
module tb_fxp_div_q16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] a;
  logic signed [31:0] b;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] q;
  logic               ovf;
  logic               div_zero;

  int checks = 0;
  int errors = 0;

  fxp_div_q16 #(.FRAC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .ovf       (ovf),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] eq;
    logic        eovf;
    logic        edz;
    int          elat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a = ia;
    b = ib;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat counts cycles after the acceptance edge: 1 means visible in the first cycle after it.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", {31'b0, out_valid}, 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;

    vecs[0]  = '{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 49};
    vecs[1]  = '{32'hFFFF_0000, 32'h0004_0000, 32'hFFFF_C000, 1'b0, 1'b0, 49};
    vecs[2]  = '{32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, 49};
    vecs[3]  = '{32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1};
    vecs[4]  = '{32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 1};
    vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1};
    vecs[6]  = '{32'h7FFF_FFFF, 32'h0000_028F, 32'h7FFF_FFFF, 1'b1, 1'b0, 49};
    vecs[7]  = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 49};
    vecs[8]  = '{32'h0000_0000, 32'h0005_0000, 32'h0000_0000, 1'b0, 1'b0, 49};
    vecs[9]  = '{32'hFFFD_0000, 32'hFFFE_0000, 32'h0001_8000, 1'b0, 1'b0, 49};
    vecs[10] = '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 49};
    vecs[11] = '{32'h8000_0000, 32'h8000_0000, 32'h0001_0000, 1'b0, 1'b0, 49};
    vecs[12] = '{32'h0007_8000, 32'hFFFE_0000, 32'hFFFC_4000, 1'b0, 1'b0, 49};
    vecs[13] = '{32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, 49};
    vecs[14] = '{32'hFFFF_8000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 49};
    vecs[15] = '{32'h0000_8000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 49};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 32'd0;
    b         = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_q",         q,                  32'd0);
    chk("rst_ovf",       {31'b0, ovf},       32'd0);
    chk("rst_div_zero",  {31'b0, div_zero},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].va, vecs[i].vb);
      wait_done(lat);
      chk($sformatf("v%0d_q", i),        q,                 vecs[i].eq);
      chk($sformatf("v%0d_ovf", i),      {31'b0, ovf},      {31'b0, vecs[i].eovf});
      chk($sformatf("v%0d_div_zero", i), {31'b0, div_zero}, {31'b0, vecs[i].edz});
      chk($sformatf("v%0d_latency", i),  32'(lat),          32'(vecs[i].elat));
      @(negedge clk);
      chk($sformatf("v%0d_in_ready_after", i), {30'b0, in_ready, out_valid}, 32'd2);
    end

    // Hold in DONE with out_ready low while a new pair is offered.
    out_ready = 1'b0;
    issue(32'h0003_0000, 32'h0002_0000);
    wait_done(lat);
    in_valid = 1'b1;
    a = 32'hFFFF_0000;
    b = 32'h0004_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_q", i),     q,  32'h0001_8000);
      chk($sformatf("hold%0d_flags", i), {28'b0, ovf, div_zero, in_ready, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", {30'b0, in_ready, out_valid}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("hold_next_accepted", {31'b0, in_ready}, 32'd0);
    wait_done(lat);
    chk("hold_next_latency", 32'(lat), 32'd49);
    chk("hold_next_q",       q,        32'hFFFF_C000);
    @(negedge clk);

    // Abort mid-CALC; operands offered during CALC must also be ignored.
    issue(32'h0003_0000, 32'h0002_0000);
    in_valid = 1'b1;
    a = 32'h0001_0000;
    b = 32'h0000_0000;
    repeat (19) @(negedge clk);
    chk("calc_in_ready", {30'b0, in_ready, out_valid}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready",  {31'b0, in_ready},  32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_q",         q,                  32'd0);
    chk("abort_flags",     {30'b0, ovf, div_zero}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    chk("abort_no_result", {31'b0, seen}, 32'd0);

    // Reset wins over a simultaneous offer in IDLE.
    in_valid = 1'b1;
    a = 32'h0001_0000;
    b = 32'h0000_0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_priority", {30'b0, in_ready, out_valid}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
